// File: rtl/adder_rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin adder arbiter.
package adder_rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int OP_W    = 18;
    localparam int ID_W    = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/adder.sv
// 18-bit Han-Carlson prefix adder: Kogge-Stone tree on odd positions, one fix-up level for even.
// Purely combinational; no state, no backpressure.
module adder (
    output logic        cout,
    output logic [17:0] sum,
    input  logic [17:0] a,
    input  logic [17:0] b,
    input  logic        cin
);

    localparam int NP = 19;

    // Position 0 carries cin as a generate; position k+1 is operand bit k.
    function automatic logic [NP-1:0] hc_carries(input logic [NP-1:0] g0, input logic [NP-1:0] p0);
        logic [NP-1:0] g;
        logic [NP-1:0] p;
        g = g0;
        p = p0;
        for (int d = 1; d < NP; d = d * 2) begin
            for (int j = NP - 2; j >= 1; j -= 2) begin
                if (j >= d) begin
                    g[j] = g[j] | (p[j] & g[j-d]);
                    p[j] = p[j] & p[j-d];
                end
            end
        end
        for (int j = 2; j < NP; j += 2) begin
            g[j] = g[j] | (p[j] & g[j-1]);
        end
        return g;
    endfunction

    logic [NP-1:0] gen0;
    logic [NP-1:0] prop0;
    logic [NP-1:0] carry;

    assign gen0  = {a & b, cin};
    assign prop0 = {a ^ b, 1'b0};
    assign carry = hc_carries(gen0, prop0);

    assign sum  = prop0[NP-1:1] ^ carry[NP-2:0];
    assign cout = carry[NP-1];

endmodule

// File: rtl/adder_rr_arb_grant.sv
// Round-robin grant picker: first valid requester at or after ptr, wrapping.
// Combinational; grants nothing while the result slot cannot accept.
module adder_rr_arb_grant import adder_rr_arb_pkg::*; #(
    parameter int N_REQ = NUM_REQ
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             can_accept_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_idx_o,
    output logic             gnt_vld_o
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr_i + ID_W'(k);
            if (can_accept_i && !found && req_valid_i[idx]) begin
                found      = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/adder_rr_arb.sv
// Four requesters share one adder round-robin; result lands in a single slot one cycle after grant.
// A full slot with rsp_ready low blocks all grants; drain and refill in one cycle leave no bubble.
module adder_rr_arb import adder_rr_arb_pkg::*; #(
    parameter int N_REQ = NUM_REQ,
    parameter int W     = OP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_cout,
    output logic [ID_W-1:0]    rsp_id
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic [ID_W-1:0] id_q, id_d;

    logic            can_accept;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_vld;

    logic [W-1:0]    op_a, op_b;
    logic            op_cin;
    logic [W-1:0]    add_sum;
    logic            add_cout;

    // Gating with rst keeps req_ready low for the whole reset window.
    assign can_accept = !rst && ((state_q == ST_EMPTY) || rsp_ready);

    adder_rr_arb_grant #(.N_REQ(N_REQ)) u_grant (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .can_accept_i(can_accept),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_vld_o   (gnt_vld)
    );

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                op_a   = req_a[i*W +: W];
                op_b   = req_b[i*W +: W];
                op_cin = req_cin[i];
            end
        end
    end

    adder u_adder (
        .cout(add_cout),
        .sum (add_sum),
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        id_d    = id_q;
        if (gnt_vld) begin
            sum_d  = add_sum;
            cout_d = add_cout;
            id_d   = gnt_idx;
            ptr_d  = gnt_idx + ID_W'(1);
        end
        case (state_q)
            ST_EMPTY: if (gnt_vld) state_d = ST_FULL;
            ST_FULL:  if (!gnt_vld && rsp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_rr_arb.sv
// Bench for adder_rr_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_adder_rr_arb;

    localparam int NR = 4;
    localparam int WW = 18;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*WW-1:0] req_a;
    logic [NR*WW-1:0] req_b;
    logic [NR-1:0]    req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WW-1:0]    rsp_sum;
    logic             rsp_cout;
    logic [1:0]       rsp_id;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adder_rr_arb dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout),
        .rsp_id   (rsp_id)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one result slot, a rotating search start, plain integer sums.
    bit            m_valid = 1'b0;
    int            m_sum = 0, m_cout = 0, m_id = 0, m_ptr = 0;
    int            wait_cnt [NR];
    logic [NR-1:0] rr_s = '0, rv_s = '0;
    int            mg, mtot;

    function automatic int model_grant();
        if (rst !== 1'b0) return -1;
        if (m_valid && rsp_ready !== 1'b1) return -1;
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0; m_sum = 0; m_cout = 0; m_id = 0; m_ptr = 0;
            for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (!rv_s[i] || rr_s[i]) wait_cnt[i] = 0;
                else if ((rr_s & rv_s) != '0) wait_cnt[i]++;
            end
            mg = model_grant();
            if (mg >= 0) begin
                mtot = int'(req_a[mg*WW +: WW]) + int'(req_b[mg*WW +: WW]) + int'(req_cin[mg]);
                m_sum   = mtot % (1 << WW);
                m_cout  = mtot / (1 << WW);
                m_id    = mg;
                m_valid = 1'b1;
                m_ptr   = (mg + 1) % NR;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int            g;
        logic [NR-1:0] er;
        g  = model_grant();
        er = (g >= 0) ? NR'(1 << g) : '0;
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_cout", rsp_cout, m_cout);
        chk("rsp_id", rsp_id, m_id);
        for (int i = 0; i < NR; i++) chk($sformatf("fair_wait%0d", i), wait_cnt[i] <= 3, 1);
        rr_s = req_ready;
        rv_s = req_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WW-1:0] a, input logic [WW-1:0] b, input logic c);
        req_a[i*WW +: WW] = a;
        req_b[i*WW +: WW] = b;
        req_cin[i]        = c;
    endtask

    function automatic logic [WW-1:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return r[WW-1:0];
        endcase
    endfunction

    logic [1:0] exp_ids [6];

    initial begin
        rst = 1'b1;
        req_valid = 4'hF;
        req_a = '0; req_b = '0; req_cin = '0;
        rsp_ready = 1'b1;
        exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd2;
        exp_ids[3] = 2'd3; exp_ids[4] = 2'd0; exp_ids[5] = 2'd1;

        // Reset values, with all requests asserted during reset.
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_rsp_id", rsp_id, 0);

        // Full-width carry out on requester 0.
        tick();
        rst = 1'b0;
        set_op(0, 18'h3FFFF, 18'h00001, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("r0_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("r0_valid", rsp_valid, 1);
        chk("r0_sum", rsp_sum, 18'h00000);
        chk("r0_cout", rsp_cout, 1);
        chk("r0_id", rsp_id, 0);

        // Reset, then all four held valid: ids 0,1,2,3,0,1 back to back.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_op(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 5) req_valid = 4'h0;
            @(negedge clk);
            chk($sformatf("rr_id%0d", k), rsp_id, exp_ids[k]);
            chk($sformatf("rr_valid%0d", k), rsp_valid, 1);
        end

        // Drain without transfer, then requester 2 alone, then 1 and 3 together.
        tick();
        set_op(2, 18'h1FFFF, 18'h20000, 1'b1);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("drain_valid", rsp_valid, 0);
        chk("drain_id_hold", rsp_id, 1);
        tick();
        set_op(1, 18'h00007, 18'h00008, 1'b0);
        set_op(3, 18'h12345, 18'h00100, 1'b0);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("r2_sum", rsp_sum, 18'h00000);
        chk("r2_cout", rsp_cout, 1);
        chk("r2_id", rsp_id, 2);
        chk("r13_req_ready", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0110;
        rsp_ready = 1'b0;

        // Three cycles of backpressure with requests on 1 and 2.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 4'h0);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 3);
            chk("bp_sum", rsp_sum, 18'h12445);
            chk("bp_cout", rsp_cout, 0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", req_ready, 4'b0010);
        tick();
        @(negedge clk);
        chk("bp_release_valid", rsp_valid, 1);
        chk("bp_release_id", rsp_id, 1);

        // Asynchronous reset with a result pending.
        tick();
        chk("pre_rst_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", rsp_valid, 0);
        chk("async_rst_ready", req_ready, 4'h0);
        tick();
        rst = 1'b0;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        chk("post_rst_id", rsp_id, 0);
        chk("post_rst_valid", rsp_valid, 1);

        // Randomized traffic with sticky requests, backpressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst       = ($urandom_range(0, 249) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) req_valid = req_valid | 4'($urandom_range(0, 15));
            else                           req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 1) == 0) set_op(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            end
        end
        tick();
        rst = 1'b0;
        req_valid = 4'h0;
        tick();
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
